// File: rtl/mips_int_ctrl.sv
// mips_int_ctrl
// Memory-mapped interrupt controller for the single-cycle MIPS core. It
// synchronises N_IRQ peripheral request lines, latches pending bits (edge or
// level per source), masks them, and raises o_ext_int for the lowest-index
// enabled pending source. The handler acknowledges through the ACK register,
// and eret closes the service window.
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_irq      asynchronous peripheral requests (N_IRQ bits)
//   i_sel      chip select from the data-memory address decoder
//   i_addr     byte offset, [4:2] selects the register
//   i_we/i_re  store / load strobes, qualified by i_sel
//   i_wdata    store data
//   o_rdata    load data (combinational, 0 unless a qualified read)
//   i_eret     high for the cycle the core executes eret
//   o_ext_int  registered interrupt request to the core
//
// Register map (offset): 0x00 PEND (W1C), 0x04 MASK, 0x08 EDGE, 0x0C ID (ro),
// 0x10 ACK (wo), 0x14 STATUS (ro), 0x18/0x1C reserved.
module mips_int_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_sel,
  input  logic [4:0]       i_addr,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  input  logic             i_eret,
  output logic             o_ext_int
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [2:0] REG_PEND   = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_EDGE   = 3'd2;
  localparam logic [2:0] REG_ID     = 3'd3;
  localparam logic [2:0] REG_ACK    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  logic [N_IRQ-1:0] r_sync1, r_sync2, r_prev;
  logic [N_IRQ-1:0] r_pend, r_mask, r_edge;
  logic [3:0]       r_insvc;
  logic             r_ext_int;
  state_t           r_state, w_next_state;

  logic             w_wr, w_rd, w_ack_wr, w_ack_take, w_id_vld;
  logic [2:0]       w_reg;
  logic [3:0]       w_ack_idx, w_id_idx;
  logic [N_IRQ-1:0] w_act, w_set, w_w1c, w_ack_clr;
  logic [15:0]      w_act16, w_ack_onehot16;
  logic             w_unused;

  assign w_wr      = i_sel & i_we;
  assign w_rd      = i_sel & i_re;
  assign w_reg     = i_addr[4:2];
  assign w_act     = r_pend & r_mask;
  assign w_ack_wr  = w_wr && (w_reg == REG_ACK);
  assign w_ack_idx = i_wdata[3:0];

  // Padding to 16 bits lets any 4-bit ACK index be looked up safely: indices
  // at or above N_IRQ land on a zero bit and are treated as not pending.
  assign w_act16        = 16'(w_act);
  assign w_ack_onehot16 = 16'd1 << w_ack_idx;
  assign w_ack_clr      = w_ack_take ? w_ack_onehot16[N_IRQ-1:0] : '0;
  assign w_w1c          = (w_wr && (w_reg == REG_PEND)) ? i_wdata[N_IRQ-1:0] : '0;

  // Level sources set every cycle they are high; edge sources only on 0->1.
  assign w_set = r_sync2 & (~r_edge | ~r_prev);

  // Address and high data bits beyond the register width are don't-care.
  assign w_unused = ^{i_addr[1:0], i_wdata};

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_id_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) w_id_idx = 4'(i);
    end
  end
  assign w_id_vld = |w_act;

  always_comb begin
    w_next_state = r_state;
    w_ack_take   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_act) w_next_state = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (w_ack_wr && w_act16[w_ack_idx]) begin
          w_ack_take   = 1'b1;
          w_next_state = ST_SERVICE;
        end else if (!(|w_act)) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (i_eret) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_ext_int <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_ext_int <= (w_next_state == ST_ASSERT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_edge  <= '0;
      r_insvc <= '0;
    end else begin
      r_sync1 <= i_irq;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      // Set beats clear: a still-high level source survives W1C and ACK.
      r_pend  <= (r_pend & ~(w_w1c | w_ack_clr)) | w_set;
      if (w_wr && (w_reg == REG_MASK)) r_mask <= i_wdata[N_IRQ-1:0];
      if (w_wr && (w_reg == REG_EDGE)) r_edge <= i_wdata[N_IRQ-1:0];
      if (w_ack_take) begin
        r_insvc <= w_ack_idx;
      end else if ((r_state == ST_SERVICE) && i_eret) begin
        r_insvc <= '0;
      end
    end
  end

  // Reads see the registers before any same-cycle write lands.
  always_comb begin
    o_rdata = '0;
    if (w_rd) begin
      case (w_reg)
        REG_PEND:   o_rdata = 32'(r_pend);
        REG_MASK:   o_rdata = 32'(r_mask);
        REG_EDGE:   o_rdata = 32'(r_edge);
        REG_ID:     if (w_id_vld) o_rdata = {1'b1, 27'd0, w_id_idx};
        REG_STATUS: o_rdata = {24'd0, r_insvc, 2'b00, 2'(r_state)};
        default:    o_rdata = '0;
      endcase
    end
  end

  assign o_ext_int = r_ext_int;

endmodule
